// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED matrix scanner: scan states,
// pin polarity mapping and row-slot length.
package led_scan_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_DRIVE
    } scan_state_e;

    // Cycles in one row slot: blanking gap followed by the PWM drive phase.
    function automatic int slot_len(input int blank, input int bright_bits);
        return blank + (1 << bright_bits);
    endfunction

    function automatic logic row_pin(input logic sel, input bit active_low);
        return sel ^ active_low;
    endfunction

    function automatic logic col_pin(input logic lit, input bit active_low);
        return lit ^ active_low;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Row-slot sequencer for the LED matrix scanner: blanking/drive phase timing,
// row counter with wrap and frame boundary detection.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_OFF   | scan disabled, row 0 / phase 0 held, pins inactive
// ST_BLANK | BLANK cycles with every row and column inactive
// ST_DRIVE | 2**BRIGHT_BITS cycles with row row_idx selected, PWM on cols
module scan_timer
    import led_scan_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int BLANK       = 2,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     nxt_drive,
    output logic [$clog2(ROWS)-1:0]  nxt_row,
    output logic [BRIGHT_BITS-1:0]   nxt_drive_cnt,
    output logic                     frame_boundary
);

    localparam int SLOT  = slot_len(BLANK, BRIGHT_BITS);
    localparam int CNT_W = $clog2(SLOT);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'((1 << BRIGHT_BITS) - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    // cnt_q is a down-counter; each phase ends when it reaches zero.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        row_d          = row_q;
        frame_boundary = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d        = ST_BLANK;
                    cnt_d          = BLANK_LAST;
                    row_d          = '0;
                    frame_boundary = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DRIVE;
                        cnt_d   = DRIVE_LAST;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LAST;
                        if (row_q == ROW_LAST) begin
                            row_d          = '0;
                            frame_boundary = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Next-cycle view lets the top register its pins in step with the state.
    assign row_idx       = row_q;
    assign nxt_drive     = (state_d == ST_DRIVE);
    assign nxt_row       = row_d;
    assign nxt_drive_cnt = BRIGHT_BITS'(DRIVE_LAST - cnt_d);

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed LED matrix driver: double-buffered image, per-row blanking,
// global PWM brightness and registered, polarity-configurable pins.
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int BLANK          = 2,
    parameter int BRIGHT_BITS    = 3,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ROWS*COLS-1:0]     pix_data,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [BRIGHT_BITS-1:0]   brightness,
    output logic [ROWS-1:0]          row_out,
    output logic [COLS-1:0]          col_out,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     frame_start
);

    localparam int N     = ROWS * COLS;
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [ROWS-1:0] ROW_IDLE = {ROWS{ROW_ACTIVE_LOW}};
    localparam logic [COLS-1:0] COL_IDLE = {COLS{COL_ACTIVE_LOW}};

    logic                   nxt_drive;
    logic [ROW_W-1:0]       nxt_row;
    logic [BRIGHT_BITS-1:0] nxt_drive_cnt;
    logic                   frame_boundary;

    logic [N-1:0]           active_q, active_d;
    logic [N-1:0]           shadow_q, shadow_d;
    logic                   pix_ready_q, pix_ready_d;
    logic [BRIGHT_BITS-1:0] bright_q, bright_d;
    logic [ROWS-1:0]        row_out_q, row_out_d;
    logic [COLS-1:0]        col_out_q, col_out_d;
    logic                   frame_start_q, frame_start_d;

    logic [COLS-1:0]        row_img;
    logic                   pwm_on;

    scan_timer #(
        .ROWS        (ROWS),
        .BLANK       (BLANK),
        .BRIGHT_BITS (BRIGHT_BITS)
    ) u_scan_timer (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .row_idx        (row_idx),
        .nxt_drive      (nxt_drive),
        .nxt_row        (nxt_row),
        .nxt_drive_cnt  (nxt_drive_cnt),
        .frame_boundary (frame_boundary)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q      <= '0;
            shadow_q      <= '0;
            pix_ready_q   <= 1'b1;
            bright_q      <= '0;
            row_out_q     <= ROW_IDLE;
            col_out_q     <= COL_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pix_ready_q   <= pix_ready_d;
            bright_q      <= bright_d;
            row_out_q     <= row_out_d;
            col_out_q     <= col_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    // pix_ready_q doubles as "shadow empty", so a swap (needs full) and an
    // accept (needs empty) can never fall on the same edge.
    always_comb begin
        active_d    = active_q;
        shadow_d    = shadow_q;
        pix_ready_d = pix_ready_q;
        bright_d    = bright_q;
        if (frame_boundary) begin
            bright_d = brightness;
            if (!pix_ready_q) begin
                active_d    = shadow_q;
                pix_ready_d = 1'b1;
            end
        end
        if (pix_valid && pix_ready_q) begin
            shadow_d    = pix_data;
            pix_ready_d = 1'b0;
        end
    end

    // Active image is never swapped on entry to DRIVE, so active_q is current.
    assign row_img = COLS'(active_q >> (int'(nxt_row) * COLS));
    assign pwm_on  = nxt_drive && (nxt_drive_cnt < bright_q);

    always_comb begin
        row_out_d     = ROW_IDLE;
        col_out_d     = COL_IDLE;
        frame_start_d = frame_boundary;
        for (int r = 0; r < ROWS; r++) begin
            row_out_d[r] = row_pin(nxt_drive && (nxt_row == ROW_W'(r)), ROW_ACTIVE_LOW);
        end
        for (int c = 0; c < COLS; c++) begin
            col_out_d[c] = col_pin(pwm_on && row_img[c], COL_ACTIVE_LOW);
        end
    end

    assign pix_ready   = pix_ready_q;
    assign row_out     = row_out_q;
    assign col_out     = col_out_q;
    assign frame_start = frame_start_q;

endmodule
